// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//
// Merges NUM_PORTS AXI-Stream inputs onto one registered AXI-Stream output.
// Arbitration is round-robin at packet granularity. Once a port is granted it
// keeps the grant until its tlast beat is accepted, so packets never
// interleave. Each output beat carries the source index on m_axis_tid.
//
// Ports:
//   clk            clock
//   resetn         asynchronous active-low reset
//   s_axis_tdata   packed input data, port i at [i*TDATA_WIDTH +: TDATA_WIDTH]
//   s_axis_tlast   per-port last-beat flag
//   s_axis_tvalid  per-port valid
//   s_axis_tready  per-port ready, at most one bit high (the granted port)
//   m_axis_tdata   registered output data
//   m_axis_tlast   registered output last flag
//   m_axis_tid     registered source port index
//   m_axis_tvalid  registered output valid
//   m_axis_tready  downstream ready
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 32,
  // Derived from NUM_PORTS; leave at its default.
  parameter int TID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [TID_WIDTH-1:0]             m_axis_tid,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [TID_WIDTH-1:0] tid_t;

  state_t                 state;
  state_t                 state_next;
  tid_t                   grant;
  tid_t                   last_grant;

  // Round-robin candidate
  logic                   pick_valid;
  tid_t                   pick_idx;
  int                     cand;

  // Granted-port view of the inputs
  logic [TDATA_WIDTH-1:0] sel_data;
  logic                   sel_last;
  logic                   sel_valid;

  logic                   can_load;
  logic                   accept;

  // ---------------------------------------------------------------------------
  // Round-robin search: first requesting port strictly after last_grant,
  // wrapping at NUM_PORTS. The loop runs from the farthest offset down to the
  // nearest so the nearest requester is the one left standing.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (s_axis_tvalid[cand[TID_WIDTH-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[TID_WIDTH-1:0];
      end
    end
  end

  // Granted-port multiplexer.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == tid_t'(i)) begin
        sel_data  = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (pick_valid)          state_next = BUSY;
      BUSY: if (accept && sel_last)  state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // FSM: outputs. The output register can take a new beat when it is empty
  // or its current beat leaves this cycle; ready reaches only the granted port.
  always_comb begin
    can_load      = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = '0;
    if (state == BUSY) s_axis_tready[grant] = can_load;
    accept        = (state == BUSY) && sel_valid && can_load;
  end

  // ---------------------------------------------------------------------------
  // Grant pointer. last_grant resets to the top port so port 0 wins first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= '0;
      last_grant <= tid_t'(NUM_PORTS - 1);
    end else if (state == IDLE && pick_valid) begin
      grant      <= pick_idx;
      last_grant <= pick_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. Applies in both states so a final beat still drains
  // during the arbitration cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (can_load) begin
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last;
        m_axis_tid    <= grant;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for axis_packet_arbiter (NUM_PORTS=4, TDATA_WIDTH=32).
// Directed cycle tables, hand-written reset/alternation sequences, then a
// randomized run scored against a packet-level round-robin model.
// -----------------------------------------------------------------------------
module tb_axis_packet_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NP*DW-1:0] s_axis_tdata = '0;
  logic [NP-1:0]   s_axis_tlast = '0;
  logic [NP-1:0]   s_axis_tvalid = '0;
  logic [NP-1:0]   s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tlast;
  logic [1:0]      m_axis_tid;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  axis_packet_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(DW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every port presents {port index, base}; this keeps the source visible in data.
  task automatic drive(input logic [3:0] valid, input logic [3:0] last,
                       input logic [23:0] base, input logic mready);
    s_axis_tvalid = valid;
    s_axis_tlast  = last;
    for (int i = 0; i < NP; i++) s_axis_tdata[i*DW +: DW] = {8'(i), base};
    m_axis_tready = mready;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    resetn = 1'b0;
    drive(4'b0000, 4'b0000, 24'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed cycle table: inputs held for one cycle, ready checked before the
  // edge, registered outputs checked after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [23:0] base;
    logic        mready;
    logic [3:0]  exp_sready;
    logic        exp_mvalid;
    logic [31:0] exp_mdata;
    logic [1:0]  exp_mtid;
    logic        exp_mlast;
  } row_t;

  row_t rows[$];

  task automatic fill_rows();
    // Port 2 alone, 3 beats.
    rows.push_back('{1'b1, 4'b0100, 4'b0000, 24'hA0, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b0100, 4'b0000, 24'hA0, 1'b1, 4'b0100, 1'b1, 32'h020000A0, 2'd2, 1'b0});
    rows.push_back('{1'b0, 4'b0100, 4'b0000, 24'hA1, 1'b1, 4'b0100, 1'b1, 32'h020000A1, 2'd2, 1'b0});
    rows.push_back('{1'b0, 4'b0100, 4'b0100, 24'hA2, 1'b1, 4'b0100, 1'b1, 32'h020000A2, 2'd2, 1'b1});
    rows.push_back('{1'b0, 4'b0000, 4'b0000, 24'h00, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    // Ports 0, 1, 3 with 2-beat packets from reset, then all four single-beat.
    rows.push_back('{1'b1, 4'b1011, 4'b0000, 24'h00, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1011, 4'b0000, 24'h00, 1'b1, 4'b0001, 1'b1, 32'h00000000, 2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1011, 4'b0001, 24'h01, 1'b1, 4'b0001, 1'b1, 32'h00000001, 2'd0, 1'b1});
    rows.push_back('{1'b0, 4'b1010, 4'b0000, 24'h00, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1010, 4'b0000, 24'h00, 1'b1, 4'b0010, 1'b1, 32'h01000000, 2'd1, 1'b0});
    rows.push_back('{1'b0, 4'b1010, 4'b0010, 24'h01, 1'b1, 4'b0010, 1'b1, 32'h01000001, 2'd1, 1'b1});
    rows.push_back('{1'b0, 4'b1000, 4'b0000, 24'h00, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1000, 4'b0000, 24'h00, 1'b1, 4'b1000, 1'b1, 32'h03000000, 2'd3, 1'b0});
    rows.push_back('{1'b0, 4'b1000, 4'b1000, 24'h01, 1'b1, 4'b1000, 1'b1, 32'h03000001, 2'd3, 1'b1});
    rows.push_back('{1'b0, 4'b1111, 4'b1111, 24'h05, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1111, 4'b1111, 24'h05, 1'b1, 4'b0001, 1'b1, 32'h00000005, 2'd0, 1'b1});
    rows.push_back('{1'b0, 4'b1110, 4'b1110, 24'h05, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1110, 4'b1110, 24'h05, 1'b1, 4'b0010, 1'b1, 32'h01000005, 2'd1, 1'b1});
    // Port 1 with downstream back-pressure for 4 cycles mid-packet.
    rows.push_back('{1'b1, 4'b0010, 4'b0000, 24'hB0, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b0010, 4'b0000, 24'hB0, 1'b1, 4'b0010, 1'b1, 32'h010000B0, 2'd1, 1'b0});
    for (int k = 0; k < 4; k++)
      rows.push_back('{1'b0, 4'b0010, 4'b0000, 24'hB1, 1'b0, 4'b0000, 1'b1, 32'h010000B0, 2'd1, 1'b0});
    rows.push_back('{1'b0, 4'b0010, 4'b0000, 24'hB1, 1'b1, 4'b0010, 1'b1, 32'h010000B1, 2'd1, 1'b0});
    rows.push_back('{1'b0, 4'b0010, 4'b0010, 24'hB2, 1'b1, 4'b0010, 1'b1, 32'h010000B2, 2'd1, 1'b1});
    rows.push_back('{1'b0, 4'b0000, 4'b0000, 24'h00, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    // Port 0 drops valid for 3 cycles mid-packet while port 3 waits.
    rows.push_back('{1'b1, 4'b1001, 4'b0000, 24'hC0, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1001, 4'b0000, 24'hC0, 1'b1, 4'b0001, 1'b1, 32'h000000C0, 2'd0, 1'b0});
    for (int k = 0; k < 3; k++)
      rows.push_back('{1'b0, 4'b1000, 4'b0000, 24'hC1, 1'b1, 4'b0001, 1'b0, 32'h0,      2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1001, 4'b1001, 24'hC1, 1'b1, 4'b0001, 1'b1, 32'h000000C1, 2'd0, 1'b1});
    rows.push_back('{1'b0, 4'b1000, 4'b1000, 24'hD0, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
    rows.push_back('{1'b0, 4'b1000, 4'b1000, 24'hD0, 1'b1, 4'b1000, 1'b1, 32'h030000D0, 2'd3, 1'b1});
    rows.push_back('{1'b0, 4'b0000, 4'b0000, 24'h00, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 1'b0});
  endtask

  task automatic apply_row(input row_t r, input int idx);
    if (r.rst) do_reset();
    drive(r.valid, r.last, r.base, r.mready);
    #1;
    check($sformatf("row%0d sready", idx), 32'(s_axis_tready), 32'(r.exp_sready));
    @(posedge clk);
    #1;
    check($sformatf("row%0d mvalid", idx), 32'(m_axis_tvalid), 32'(r.exp_mvalid));
    if (r.exp_mvalid) begin
      check($sformatf("row%0d mdata", idx), m_axis_tdata, r.exp_mdata);
      check($sformatf("row%0d mtid", idx),  32'(m_axis_tid), 32'(r.exp_mtid));
      check($sformatf("row%0d mlast", idx), 32'(m_axis_tlast), 32'(r.exp_mlast));
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Asynchronous reset in the middle of a port 2 packet.
  // ---------------------------------------------------------------------------
  task automatic reset_mid_packet();
    do_reset();
    drive(4'b0100, 4'b0000, 24'hE0, 1'b1);
    @(posedge clk); @(negedge clk);
    #1 check("rst_mid busy sready", 32'(s_axis_tready), 32'h4);
    @(posedge clk);
    #1 check("rst_mid first beat", m_axis_tdata, 32'h020000E0);
    @(negedge clk);
    drive(4'b0100, 4'b0000, 24'hE1, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid mvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_mid mdata", m_axis_tdata, 32'h0);
    check("rst_mid sready", 32'(s_axis_tready), 32'h0);
    @(posedge clk); @(negedge clk);
    // Ports 1, 2, 3 request; a pointer restored to port 3 picks port 1.
    drive(4'b1110, 4'b1110, 24'hE1, 1'b1);
    resetn = 1'b1;
    #1 check("rst_after idle sready", 32'(s_axis_tready), 32'h0);
    @(posedge clk); @(negedge clk);
    #1 check("rst_after grant sready", 32'(s_axis_tready), 32'h2);
    @(posedge clk);
    #1;
    check("rst_after mtid", 32'(m_axis_tid), 32'h1);
    check("rst_after mdata", m_axis_tdata, 32'h010000E1);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Ports 0 and 1 stream single-beat packets; grants alternate with one
  // arbitration cycle before each.
  // ---------------------------------------------------------------------------
  task automatic alternate_single_beats();
    int g;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(4'b0011, 4'b0011, 24'(k >> 1), 1'b1);
      g = (k >> 1) % 2;
      #1;
      if (k % 2 == 0) check($sformatf("alt%0d idle sready", k), 32'(s_axis_tready), 32'h0);
      else            check($sformatf("alt%0d sready", k), 32'(s_axis_tready), 32'(1 << g));
      @(posedge clk);
      #1;
      if (k % 2 == 0) begin
        check($sformatf("alt%0d idle mvalid", k), 32'(m_axis_tvalid), 32'h0);
      end else begin
        check($sformatf("alt%0d mtid", k), 32'(m_axis_tid), 32'(g));
        check($sformatf("alt%0d mdata", k), m_axis_tdata, {8'(g), 24'(k >> 1)});
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run. Each port owns a list of packets; the expected egress
  // stream is built up front by a packet-level round-robin over the ports
  // that still hold packets. Sources keep the first beat of the next packet
  // valid immediately, so every port with packets left requests at each
  // arbitration point; mid-packet gaps and downstream stalls are random.
  // ---------------------------------------------------------------------------
  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  typedef struct packed {logic [31:0] data; logic [1:0] tid; logic last;} obeat_t;

  task automatic run_random();
    beat_t  src_q[NP][$];
    beat_t  mdl_q[NP][$];
    obeat_t exp_q[$];
    int     gap[NP];
    int     npkt_total;
    int     lastg;
    beat_t  b;
    obeat_t e;
    logic [3:0]  sr, vld, acc;
    logic        mv, ml, mr;
    logic [31:0] md;
    logic [1:0]  mt;
    logic        hold_prev;
    logic [31:0] prev_d;
    logic [1:0]  prev_t;
    logic        prev_l;
    int          cyc;

    npkt_total = 0;
    for (int p = 0; p < NP; p++) begin
      int npkt;
      gap[p] = 0;
      npkt = $urandom_range(0, 6);
      npkt_total += npkt;
      for (int k = 0; k < npkt; k++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          b.data = $urandom;
          b.last = (j == len - 1);
          src_q[p].push_back(b);
          mdl_q[p].push_back(b);
        end
      end
    end

    lastg = NP - 1;
    for (int n = 0; n < npkt_total; n++) begin
      for (int off = 1; off <= NP; off++) begin
        int p;
        p = (lastg + off) % NP;
        if (mdl_q[p].size() > 0) begin
          do begin
            b = mdl_q[p].pop_front();
            exp_q.push_back('{b.data, 2'(p), b.last});
          end while (!b.last);
          lastg = p;
          break;
        end
      end
    end

    do_reset();
    hold_prev = 1'b0;
    prev_d = '0; prev_t = '0; prev_l = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NP; i++) begin
        vld[i] = (src_q[i].size() > 0) && (gap[i] == 0);
        if (src_q[i].size() > 0) begin
          s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
          s_axis_tlast[i]          = src_q[i][0].last;
        end else begin
          s_axis_tdata[i*DW +: DW] = '0;
          s_axis_tlast[i]          = 1'b0;
        end
      end
      s_axis_tvalid = vld;
      m_axis_tready = ($urandom_range(0, 9) < 7);
      #1;
      sr = s_axis_tready; mv = m_axis_tvalid; md = m_axis_tdata;
      mt = m_axis_tid;    ml = m_axis_tlast;  mr = m_axis_tready;
      check("rand sready onehot", 32'($countones(sr) <= 1), 32'h1);
      if (hold_prev) begin
        check("rand hold mvalid", 32'(mv), 32'h1);
        check("rand hold mdata", md, prev_d);
        check("rand hold mtid", 32'(mt), 32'(prev_t));
        check("rand hold mlast", 32'(ml), 32'(prev_l));
      end
      hold_prev = mv && !mr;
      prev_d = md; prev_t = mt; prev_l = ml;
      if (mv && mr) begin
        if (exp_q.size() == 0) begin
          check("rand extra beat", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("rand mdata", md, e.data);
          check("rand mtid", 32'(mt), 32'(e.tid));
          check("rand mlast", 32'(ml), 32'(e.last));
        end
      end
      acc = sr & vld;
      @(posedge clk);
      for (int i = 0; i < NP; i++) begin
        if (acc[i]) begin
          b = src_q[i].pop_front();
          gap[i] = b.last ? 0 : $urandom_range(0, 2);
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
      end
    end
    check("rand beats left undelivered", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < NP; i++)
      check($sformatf("rand src%0d drained", i), 32'(src_q[i].size()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    #1;
    check("reset mvalid", 32'(m_axis_tvalid), 32'h0);
    check("reset mdata", m_axis_tdata, 32'h0);
    check("reset mlast", 32'(m_axis_tlast), 32'h0);
    check("reset mtid", 32'(m_axis_tid), 32'h0);
    check("reset sready", 32'(s_axis_tready), 32'h0);
    @(negedge clk);

    fill_rows();
    foreach (rows[i]) apply_row(rows[i], i);

    reset_mid_packet();
    alternate_single_beats();
    run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream inputs onto one AXI-Stream output.
- A grant is held from the first beat of a packet until its tlast beat is accepted; packets are never interleaved.
- The output is registered and carries the source index on m_axis_tid, so a downstream router or register stage can attribute each packet.
- Sits upstream of the router's register stages and shares the single egress datapath between ingress ports.

Parameters:
- NUM_PORTS, 4, number of input streams (2..16).
- TDATA_WIDTH, 32, data width per stream.
- TID_WIDTH, $clog2(NUM_PORTS), width of m_axis_tid (derived; do not override).

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- s_axis_tdata  input  NUM_PORTS*TDATA_WIDTH  packed input data; port i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tlast  input  NUM_PORTS  per-port last-beat flag.
- s_axis_tvalid  input  NUM_PORTS  per-port valid.
- s_axis_tready  output  NUM_PORTS  per-port ready; at most one bit is high at any time.
- m_axis_tdata  output  TDATA_WIDTH  registered output data.
- m_axis_tlast  output  1  registered last flag.
- m_axis_tid  output  TID_WIDTH  registered index of the source port.
- m_axis_tvalid  output  1  registered valid.
- m_axis_tready  input  1  downstream ready.

Behaviour:
- Clocking and reset: one clock domain, clk. resetn is asynchronous and active-low.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0.
  - s_axis_tready=all 0.
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1, so port 0 has first priority.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - All s_axis_tready are 0.
  - If any s_axis_tvalid is set, select the first set bit searching upward from last_grant+1, wrapping modulo NUM_PORTS.
  - Register the selection into grant and last_grant, then go to BUSY.
  - If no s_axis_tvalid is set, stay in IDLE.
- BUSY:
  - can_load = !m_axis_tvalid | m_axis_tready.
  - s_axis_tready[grant] = can_load; all other ready bits are 0. This path is combinational.
  - A beat is accepted when s_axis_tvalid[grant] & s_axis_tready[grant]. On acceptance, the output registers load data, tlast and tid=grant, and m_axis_tvalid is set to 1.
  - If can_load is high but no beat is accepted, m_axis_tvalid is cleared to 0.
  - If can_load is low, the output registers hold.
  - When an accepted beat has tlast=1, go to IDLE.
  - tvalid gaps on the granted port mid-packet do not release the grant.
- Timing:
  - Latency is 1 clk from beat acceptance to the beat appearing on m_axis.
  - Arbitration costs exactly one IDLE cycle between packets, giving a 1-cycle bubble on the input side.
  - The output side still drains back-to-back if the final beat has not yet left.
- Fairness: after port k completes a packet, port k has the lowest priority. Wrap is from NUM_PORTS-1 to 0.
- Simultaneous requests: only the round-robin pointer decides. A request asserted in the same cycle as the IDLE decision is eligible.
- Single-beat packets (tvalid and tlast on the first beat) are legal: BUSY lasts one accepted beat.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, tlast and tid are held stable.
- Reset mid-packet:
  - Everything returns to reset values and any registered output beat is discarded.
  - The remainder of an interrupted upstream packet is treated as a new packet on its next grant. Upstream must flush on reset.
- No packet length limit and no timeout: a granted port that stalls indefinitely blocks all other ports. This is by design.

Test Plan:
1. Port 2 alone sends 3 beats (0xA0, 0xA1, 0xA2 with tlast) while m_axis_tready=1 → after 1 IDLE cycle, m_axis shows the three beats on consecutive cycles with tid=2, tlast on 0xA2 only; then s_axis_tready returns to 0000.
2. Ports 0, 1 and 3 each hold a 2-beat packet valid from reset → packets are output in order tid 0, 1, 3. A second round with all ports valid after last_grant=3 is granted to port 0 first.
3. Port 1 is mid-packet with m_axis_tready held 0 for 4 cycles → m_axis_tvalid stays 1 with data stable; s_axis_tready[1]=0; no beat is lost or duplicated once ready returns.
4. Port 0 deasserts tvalid for 3 cycles mid-packet while port 3 is valid → grant stays on port 0 (s_axis_tready[3]=0) until port 0's tlast is accepted; then port 3 is granted.
5. resetn is pulsed low asynchronously (between clock edges) during the second beat of a port 2 packet → m_axis_tvalid=0 and s_axis_tready=0000 immediately. After release, the first grant goes to the lowest valid port starting from port 0.
6. Ports 0 and 1 each stream a single-beat packet continuously for 8 packets → grants strictly alternate 0, 1, 0, 1, …, with one IDLE cycle before each grant.
